// File: rtl/mem_stage_pkg.sv
// Shared widths, bundle bit indices, access-size and FSM state encodings for mem_stage.
package mem_stage_pkg;

    localparam int unsigned REG_BUS_W      = 64;
    localparam int unsigned REG_CTRL_BUS_W = 4;

    typedef logic [REG_BUS_W-1:0]      reg_bus_t;
    typedef logic [REG_CTRL_BUS_W-1:0] reg_ctrl_bus_t;

    // One-hot writeback source select bit positions
    localparam int unsigned MEM_TO_REG = 0;
    localparam int unsigned PC_TO_REG  = 1;
    localparam int unsigned EXE_TO_REG = 2;
    localparam int unsigned CSR_TO_REG = 3;

    // exe_mem_ctrl = {unsigned, size[1:0], store, load}
    localparam int unsigned MC_LOAD     = 0;
    localparam int unsigned MC_STORE    = 1;
    localparam int unsigned MC_SIZE_LO  = 2;
    localparam int unsigned MC_SIZE_HI  = 3;
    localparam int unsigned MC_UNSIGNED = 4;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_RESP = 2'b10,
        S_DONE = 2'b11
    } mem_state_e;

    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = off[0];
            2'b10:   r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane alignment: store data shift / byte mask and load extract / extend.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0] i_off,
    input  mem_size_e  i_size,
    input  logic       i_unsigned,
    input  reg_bus_t   i_st_data,
    input  reg_bus_t   i_rdata,
    output reg_bus_t   o_wdata,
    output logic [7:0] o_wmask,
    output reg_bus_t   o_ld_data
);

    logic [5:0] w_bit_off;
    logic [7:0] w_base_mask;
    reg_bus_t   w_ld_shift;
    logic       w_sext;

    assign w_bit_off  = {i_off, 3'b000};
    assign o_wdata    = i_st_data << w_bit_off;
    assign w_ld_shift = i_rdata >> w_bit_off;
    // Lanes shifted past byte 7 fall off the 8-bit mask
    assign o_wmask    = w_base_mask << i_off;

    always_comb begin
        w_base_mask = 8'hFF;
        w_sext      = 1'b0;
        o_ld_data   = w_ld_shift;
        case (i_size)
            SIZE_B: begin
                w_base_mask = 8'h01;
                w_sext      = ~i_unsigned & w_ld_shift[7];
                o_ld_data   = {{(REG_BUS_W-8){w_sext}}, w_ld_shift[7:0]};
            end
            SIZE_H: begin
                w_base_mask = 8'h03;
                w_sext      = ~i_unsigned & w_ld_shift[15];
                o_ld_data   = {{(REG_BUS_W-16){w_sext}}, w_ld_shift[15:0]};
            end
            SIZE_W: begin
                w_base_mask = 8'h0F;
                w_sext      = ~i_unsigned & w_ld_shift[31];
                o_ld_data   = {{(REG_BUS_W-32){w_sext}}, w_ld_shift[31:0]};
            end
            default: begin
                w_base_mask = 8'hFF;
                o_ld_data   = w_ld_shift;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one dmem request per instruction, aligned load/store data.
// Optional MEM_MISALIGN_CHECK_EN: misaligned accesses skip the request and raise mem_misalign.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned REG_CTRL_W = REG_CTRL_BUS_W,
    parameter int unsigned XLEN       = REG_BUS_W
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exe_valid,
    output logic                  mem_allowin,
    input  logic [REG_CTRL_W-1:0] exe_reg_wr_ctrl,
    input  logic [4:0]            exe_rd,
    input  logic [XLEN-1:0]       exe_data,
    input  logic [XLEN-1:0]       exe_st_data,
    input  logic [XLEN-1:0]       exe_pc,
    input  logic [XLEN-1:0]       exe_csr_data,
    input  logic [4:0]            exe_mem_ctrl,
    input  logic                  wb_allowin,
    output logic                  mem_valid,
    output logic [REG_CTRL_W-1:0] mem_reg_wr_ctrl,
    output logic [4:0]            mem_rd,
    output logic [XLEN-1:0]       mem_exe_data,
    output logic [XLEN-1:0]       mem_pc_data,
    output logic [XLEN-1:0]       mem_csr_data,
    output logic [XLEN-1:0]       mem_mem_data,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    output logic [7:0]            dmem_wmask,
    input  logic                  dmem_resp_valid,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  mem_misalign
);

    mem_state_e            r_state;
    mem_state_e            w_next_state;
    mem_state_e            w_accept_state;

    logic [REG_CTRL_W-1:0] r_ctrl;
    logic [4:0]            r_rd;
    logic [XLEN-1:0]       r_exe;
    logic [XLEN-1:0]       r_st;
    logic [XLEN-1:0]       r_pc;
    logic [XLEN-1:0]       r_csr;
    logic [XLEN-1:0]       r_mem_data;
    logic                  r_store;
    logic                  r_unsigned;
    mem_size_e             r_size;

    logic                  w_accept;
    logic                  w_in_is_mem;
    logic                  w_in_misalign;
    logic                  w_in_req;
    logic [XLEN-1:0]       w_wdata;
    logic [7:0]            w_wmask;
    logic [XLEN-1:0]       w_ld_data;

    assign mem_allowin = (r_state == S_IDLE) | ((r_state == S_DONE) & wb_allowin);
    assign w_accept    = exe_valid & mem_allowin;
    assign w_in_is_mem = exe_mem_ctrl[MC_LOAD] | exe_mem_ctrl[MC_STORE];

`ifdef MEM_MISALIGN_CHECK_EN
    logic r_misalign;

    assign w_in_misalign = w_in_is_mem &
                           is_misaligned(exe_data[2:0], exe_mem_ctrl[MC_SIZE_HI:MC_SIZE_LO]);
    assign mem_misalign  = r_misalign;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_misalign <= w_in_misalign;
        end
    end
`else
    assign w_in_misalign = 1'b0;
    assign mem_misalign  = 1'b0;
`endif

    assign w_in_req = w_in_is_mem & ~w_in_misalign;

    always_comb begin
        w_accept_state = w_in_req ? S_REQ : S_DONE;
        w_next_state   = r_state;
        case (r_state)
            S_IDLE: if (exe_valid)       w_next_state = w_accept_state;
            S_REQ:  if (dmem_req_ready)  w_next_state = r_store ? S_DONE : S_RESP;
            S_RESP: if (dmem_resp_valid) w_next_state = S_DONE;
            S_DONE: if (wb_allowin)      w_next_state = exe_valid ? w_accept_state : S_IDLE;
            default:                     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ctrl     <= '0;
            r_rd       <= '0;
            r_exe      <= '0;
            r_st       <= '0;
            r_pc       <= '0;
            r_csr      <= '0;
            r_mem_data <= '0;
            r_store    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= SIZE_B;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_ctrl     <= w_in_misalign ? '0 : exe_reg_wr_ctrl;
                r_rd       <= exe_rd;
                r_exe      <= exe_data;
                r_st       <= exe_st_data;
                r_pc       <= exe_pc;
                r_csr      <= exe_csr_data;
                r_mem_data <= '0;
                r_store    <= exe_mem_ctrl[MC_STORE];
                r_unsigned <= exe_mem_ctrl[MC_UNSIGNED];
                r_size     <= mem_size_e'(exe_mem_ctrl[MC_SIZE_HI:MC_SIZE_LO]);
            end else if ((r_state == S_RESP) && dmem_resp_valid) begin
                r_mem_data <= w_ld_data;
            end
        end
    end

    mem_align u_align (
        .i_off      (r_exe[2:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_st_data  (r_st),
        .i_rdata    (dmem_rdata),
        .o_wdata    (w_wdata),
        .o_wmask    (w_wmask),
        .o_ld_data  (w_ld_data)
    );

    // Request fields come from the latched bundle, so they stay put until the handshake
    assign dmem_req_valid  = (r_state == S_REQ);
    assign dmem_we         = dmem_req_valid & r_store;
    assign dmem_addr       = {r_exe[XLEN-1:3], 3'b000};
    assign dmem_wdata      = dmem_req_valid ? w_wdata : '0;
    assign dmem_wmask      = dmem_req_valid ? w_wmask : '0;

    assign mem_valid       = (r_state == S_DONE);
    assign mem_reg_wr_ctrl = r_ctrl;
    assign mem_rd          = r_rd;
    assign mem_exe_data    = r_exe;
    assign mem_pc_data     = r_pc;
    assign mem_csr_data    = r_csr;
    assign mem_mem_data    = r_mem_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic vs. a byte-level model.
`timescale 1ns/1ps
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid;
    logic        mem_allowin;
    logic [3:0]  exe_reg_wr_ctrl;
    logic [4:0]  exe_rd;
    logic [63:0] exe_data;
    logic [63:0] exe_st_data;
    logic [63:0] exe_pc;
    logic [63:0] exe_csr_data;
    logic [4:0]  exe_mem_ctrl;
    logic        wb_allowin;
    logic        mem_valid;
    logic [3:0]  mem_reg_wr_ctrl;
    logic [4:0]  mem_rd;
    logic [63:0] mem_exe_data;
    logic [63:0] mem_pc_data;
    logic [63:0] mem_csr_data;
    logic [63:0] mem_mem_data;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_resp_valid;
    logic [63:0] dmem_rdata;
    logic        mem_misalign;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.REG_CTRL_W(4), .XLEN(64)) dut (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .mem_allowin(mem_allowin),
        .exe_reg_wr_ctrl(exe_reg_wr_ctrl), .exe_rd(exe_rd), .exe_data(exe_data),
        .exe_st_data(exe_st_data), .exe_pc(exe_pc), .exe_csr_data(exe_csr_data),
        .exe_mem_ctrl(exe_mem_ctrl), .wb_allowin(wb_allowin), .mem_valid(mem_valid),
        .mem_reg_wr_ctrl(mem_reg_wr_ctrl), .mem_rd(mem_rd), .mem_exe_data(mem_exe_data),
        .mem_pc_data(mem_pc_data), .mem_csr_data(mem_csr_data), .mem_mem_data(mem_mem_data),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata), .mem_misalign(mem_misalign)
    );

    // ---------------- reference model (byte-lane view) ----------------
    function automatic logic [63:0] ref_wdata(input logic [63:0] st, input logic [63:0] addr);
        return st << (8 * (addr % 8));
    endfunction

    function automatic logic [7:0] ref_wmask(input logic [63:0] addr, input logic [4:0] mc);
        int unsigned off, nbytes;
        logic [7:0]  m;
        off    = int'(addr % 8);
        nbytes = 1 << mc[3:2];
        m      = '0;
        for (int unsigned b = 0; b < nbytes; b++)
            if (off + b < 8) m[off + b] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [63:0] addr,
                                             input logic [4:0] mc);
        int unsigned off, nbytes;
        logic [63:0] v;
        off    = int'(addr % 8);
        nbytes = 1 << mc[3:2];
        v      = '0;
        for (int unsigned b = 0; b < nbytes; b++)
            if (off + b < 8) v[8*b +: 8] = rdata[8*(off+b) +: 8];
        if (nbytes < 8 && !mc[4] && v[8*nbytes-1])
            for (int unsigned k = 8*nbytes; k < 64; k++) v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic ref_misaligned(input logic [63:0] addr, input logic [4:0] mc);
        int unsigned nbytes;
        nbytes = 1 << mc[3:2];
`ifdef MEM_MISALIGN_CHECK_EN
        return (mc[1:0] != 2'b00) && ((addr % nbytes) != 0);
`else
        return (nbytes == 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; exe_valid = 1'b1; exe_mem_ctrl = 5'b00001; exe_data = 64'h1008;
        exe_reg_wr_ctrl = 4'b0001; exe_rd = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_valid, dmem_req_valid, dmem_we, mem_allowin, mem_misalign} !== 5'b00010) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00010", {mem_valid, dmem_req_valid, dmem_we, mem_allowin, mem_misalign});
        end
        checks++;
        if ({mem_exe_data, mem_pc_data, mem_csr_data, mem_mem_data} !== 256'd0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {mem_exe_data, mem_pc_data, mem_csr_data, mem_mem_data});
        end
        checks++;
        if ({mem_reg_wr_ctrl, mem_rd, dmem_wmask, dmem_addr, dmem_wdata} !== 145'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %h expected 0", {mem_reg_wr_ctrl, mem_rd, dmem_wmask, dmem_addr, dmem_wdata});
        end
        exe_valid = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_nonmem();
        exe_reg_wr_ctrl = 4'b0100; exe_rd = 5'd7; exe_data = 64'h1234; exe_pc = 64'h8000_0000;
        exe_csr_data = 64'h55; exe_st_data = 64'hDEAD; exe_mem_ctrl = 5'b00000; exe_valid = 1'b1;
        #1;
        checks++;
        if (mem_allowin !== 1'b1) begin
            failures++; $display("FAIL nonmem_allowin: got %b expected 1", mem_allowin);
        end
        tick();
        exe_valid = 1'b0;
        checks++;
        if ({mem_valid, dmem_req_valid} !== 2'b10) begin
            failures++; $display("FAIL nonmem_valid: got %b expected 10", {mem_valid, dmem_req_valid});
        end
        checks++;
        if ({mem_exe_data, mem_mem_data} !== {64'h1234, 64'h0}) begin
            failures++; $display("FAIL nonmem_data: got %h/%h expected 1234/0", mem_exe_data, mem_mem_data);
        end
        checks++;
        if ({mem_reg_wr_ctrl, mem_rd, mem_pc_data, mem_csr_data} !== {4'b0100, 5'd7, 64'h8000_0000, 64'h55}) begin
            failures++; $display("FAIL nonmem_bundle: got %h %h %h %h", mem_reg_wr_ctrl, mem_rd, mem_pc_data, mem_csr_data);
        end
        tick();
        checks++;
        if (mem_valid !== 1'b0) begin
            failures++; $display("FAIL nonmem_retire: got %b expected 0", mem_valid);
        end
    endtask

    task automatic test_load_byte(input logic uns);
        logic [63:0] exp;
        exp = uns ? 64'h80 : 64'hFFFF_FFFF_FFFF_FF80;
        exe_data = 64'h1003; exe_mem_ctrl = {uns, 2'b00, 1'b0, 1'b1}; exe_reg_wr_ctrl = 4'b0001;
        exe_st_data = '0; dmem_req_ready = 1'b0; exe_valid = 1'b1;
        tick();
        exe_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dmem_req_valid, dmem_we, dmem_addr} !== {1'b1, 1'b0, 64'h1000}) begin
                failures++;
                $display("FAIL ldb_req_hold: cycle %0d got v=%b we=%b addr=%h expected 1 0 1000", i, dmem_req_valid, dmem_we, dmem_addr);
            end
            if (i < 2) tick();
        end
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        checks++;
        if ({dmem_req_valid, mem_valid} !== 2'b00) begin
            failures++; $display("FAIL ldb_wait_resp: got %b expected 00", {dmem_req_valid, mem_valid});
        end
        dmem_rdata = 64'h0000_0000_8000_0000; dmem_resp_valid = 1'b1;
        tick();
        dmem_resp_valid = 1'b0; dmem_rdata = '0;
        checks++;
        if ({mem_valid, mem_mem_data} !== {1'b1, exp}) begin
            failures++; $display("FAIL ldb_data uns=%b: got v=%b %h expected 1 %h", uns, mem_valid, mem_mem_data, exp);
        end
        tick();
    endtask

    task automatic test_store_half();
        exe_data = 64'h2006; exe_st_data = 64'hABCD; exe_mem_ctrl = 5'b00110;
        exe_reg_wr_ctrl = 4'b0000; exe_valid = 1'b1;
        tick();
        exe_valid = 1'b0;
        checks++;
        if ({dmem_req_valid, dmem_we, dmem_addr} !== {1'b1, 1'b1, 64'h2000}) begin
            failures++; $display("FAIL sth_req: got v=%b we=%b addr=%h expected 1 1 2000", dmem_req_valid, dmem_we, dmem_addr);
        end
        checks++;
        if ({dmem_wdata, dmem_wmask} !== {64'hABCD_0000_0000_0000, 8'hC0}) begin
            failures++; $display("FAIL sth_lane: got %h mask %h expected abcd000000000000 mask c0", dmem_wdata, dmem_wmask);
        end
        checks++;
        if (mem_valid !== 1'b0) begin
            failures++; $display("FAIL sth_early_valid: got %b expected 0", mem_valid);
        end
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        checks++;
        if ({mem_valid, dmem_req_valid, mem_mem_data} !== {1'b1, 1'b0, 64'h0}) begin
            failures++; $display("FAIL sth_done: got v=%b req=%b data=%h expected 1 0 0", mem_valid, dmem_req_valid, mem_mem_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        wb_allowin = 1'b0;
        exe_data = 64'hA1; exe_rd = 5'd10; exe_mem_ctrl = 5'b00000; exe_reg_wr_ctrl = 4'b0100; exe_valid = 1'b1;
        tick();
        exe_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_valid, mem_allowin, mem_exe_data, mem_rd} !== {1'b1, 1'b0, 64'hA1, 5'd10}) begin
                failures++;
                $display("FAIL b2b_hold: cycle %0d got v=%b allowin=%b data=%h rd=%0d expected 1 0 a1 10", i, mem_valid, mem_allowin, mem_exe_data, mem_rd);
            end
            tick();
        end
        exe_data = 64'hB2; exe_rd = 5'd11; exe_valid = 1'b1; wb_allowin = 1'b1;
        #1;
        checks++;
        if (mem_allowin !== 1'b1) begin
            failures++; $display("FAIL b2b_allowin: got %b expected 1", mem_allowin);
        end
        tick();
        exe_valid = 1'b0;
        checks++;
        if ({mem_valid, mem_exe_data, mem_rd} !== {1'b1, 64'hB2, 5'd11}) begin
            failures++; $display("FAIL b2b_next: got v=%b data=%h rd=%0d expected 1 b2 11", mem_valid, mem_exe_data, mem_rd);
        end
        tick();
    endtask

    task automatic test_reset_in_resp();
        exe_data = 64'h3000; exe_mem_ctrl = 5'b01101; exe_reg_wr_ctrl = 4'b0001; exe_valid = 1'b1;
        dmem_req_ready = 1'b1;
        tick();
        exe_valid = 1'b0;
        tick();
        dmem_req_ready = 1'b0;
        checks++;
        if ({dmem_req_valid, mem_valid} !== 2'b00) begin
            failures++; $display("FAIL rresp_in_resp: got %b expected 00", {dmem_req_valid, mem_valid});
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        dmem_rdata = 64'h0123_4567_89AB_CDEF; dmem_resp_valid = 1'b1;
        tick();
        dmem_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({mem_valid, dmem_req_valid, mem_allowin, mem_mem_data} !== {3'b001, 64'h0}) begin
                failures++;
                $display("FAIL rresp_ignored: cycle %0d got v=%b req=%b allowin=%b data=%h expected 0 0 1 0", i, mem_valid, dmem_req_valid, mem_allowin, mem_mem_data);
            end
            tick();
        end
    endtask

    task automatic test_misalign();
        exe_data = 64'h1002; exe_mem_ctrl = 5'b01001; exe_reg_wr_ctrl = 4'b0001; exe_valid = 1'b1;
        tick();
        exe_valid = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        checks++;
        if ({dmem_req_valid, mem_valid, mem_misalign, mem_reg_wr_ctrl} !== 7'b0110000) begin
            failures++; $display("FAIL mis_flag: got %b expected 0110000", {dmem_req_valid, mem_valid, mem_misalign, mem_reg_wr_ctrl});
        end
        exe_data = 64'h40; exe_mem_ctrl = 5'b00000; exe_reg_wr_ctrl = 4'b0100; exe_valid = 1'b1;
        tick();
        exe_valid = 1'b0;
        checks++;
        if ({mem_valid, mem_misalign, mem_reg_wr_ctrl} !== 6'b100100) begin
            failures++; $display("FAIL mis_clear: got %b expected 100100", {mem_valid, mem_misalign, mem_reg_wr_ctrl});
        end
        tick();
`else
        checks++;
        if ({dmem_req_valid, mem_misalign, dmem_addr} !== {2'b10, 64'h1000}) begin
            failures++; $display("FAIL mis_issue: got req=%b mis=%b addr=%h expected 1 0 1000", dmem_req_valid, mem_misalign, dmem_addr);
        end
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        dmem_rdata = 64'h1122_3344_5566_7788; dmem_resp_valid = 1'b1;
        tick();
        dmem_resp_valid = 1'b0;
        checks++;
        if ({mem_valid, mem_mem_data} !== {1'b1, 64'h3344_5566}) begin
            failures++; $display("FAIL mis_load: got v=%b %h expected 1 33445566", mem_valid, mem_mem_data);
        end
        tick();
`endif
    endtask

    task automatic test_random();
        int unsigned kind, dly;
        logic [4:0]  mc;
        logic        mis;
        logic [63:0] rdata;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 2);
            mc   = {1'($urandom), 2'($urandom), 2'b00};
            if (kind == 1) mc[0] = 1'b1;
            if (kind == 2) mc[1:0] = {1'b1, 1'($urandom)};
            exe_data = {$urandom, $urandom}; exe_st_data = {$urandom, $urandom};
            exe_pc = {$urandom, $urandom}; exe_csr_data = {$urandom, $urandom};
            exe_rd = 5'($urandom); exe_reg_wr_ctrl = 4'($urandom); exe_mem_ctrl = mc;
            mis = (kind != 0) && ref_misaligned(exe_data, mc);
            exe_valid = 1'b1;
            #1;
            checks++;
            if (mem_allowin !== 1'b1) begin
                failures++; $display("FAIL rnd_allowin: iter %0d got %b expected 1", n, mem_allowin);
            end
            tick();
            exe_valid = 1'b0;
            if (kind == 0 || mis) begin
                checks++;
                if ({mem_valid, dmem_req_valid, mem_mem_data} !== {2'b10, 64'h0}) begin
                    failures++; $display("FAIL rnd_direct: iter %0d got v=%b req=%b data=%h expected 1 0 0", n, mem_valid, dmem_req_valid, mem_mem_data);
                end
            end else begin
                dly = $urandom_range(0, 3);
                for (int unsigned c = 0; c <= dly; c++) begin
                    checks++;
                    if ({dmem_req_valid, dmem_we, dmem_addr} !== {1'b1, kind == 2, exe_data & ~64'h7}) begin
                        failures++;
                        $display("FAIL rnd_req: iter %0d got v=%b we=%b addr=%h expected 1 %0d %h", n, dmem_req_valid, dmem_we, dmem_addr, kind == 2, exe_data & ~64'h7);
                    end
                    if (kind == 2) begin
                        checks++;
                        if ({dmem_wdata, dmem_wmask} !== {ref_wdata(exe_st_data, exe_data), ref_wmask(exe_data, mc)}) begin
                            failures++;
                            $display("FAIL rnd_store_lane: iter %0d got %h/%h expected %h/%h", n, dmem_wdata, dmem_wmask, ref_wdata(exe_st_data, exe_data), ref_wmask(exe_data, mc));
                        end
                    end
                    if (c == dly) dmem_req_ready = 1'b1;
                    tick();
                end
                dmem_req_ready = 1'b0;
                if (kind == 1) begin
                    dly = $urandom_range(0, 3);
                    for (int unsigned c = 0; c < dly; c++) begin
                        checks++;
                        if ({mem_valid, dmem_req_valid} !== 2'b00) begin
                            failures++; $display("FAIL rnd_resp_wait: iter %0d got %b expected 00", n, {mem_valid, dmem_req_valid});
                        end
                        tick();
                    end
                    rdata = {$urandom, $urandom};
                    dmem_rdata = rdata; dmem_resp_valid = 1'b1;
                    tick();
                    dmem_resp_valid = 1'b0;
                end else begin
                    rdata = '0;
                end
                checks++;
                if ({mem_valid, mem_mem_data} !== {1'b1, (kind == 1) ? ref_load(rdata, exe_data, mc) : 64'h0}) begin
                    failures++;
                    $display("FAIL rnd_result: iter %0d mc=%b addr=%h got v=%b %h expected 1 %h", n, mc, exe_data, mem_valid, mem_mem_data, (kind == 1) ? ref_load(rdata, exe_data, mc) : 64'h0);
                end
            end
            checks++;
            if ({mem_rd, mem_exe_data, mem_pc_data, mem_csr_data} !== {exe_rd, exe_data, exe_pc, exe_csr_data}) begin
                failures++; $display("FAIL rnd_passthru: iter %0d got %h %h %h %h", n, mem_rd, mem_exe_data, mem_pc_data, mem_csr_data);
            end
            checks++;
            if ({mem_reg_wr_ctrl, mem_misalign} !== {mis ? 4'b0000 : exe_reg_wr_ctrl, mis}) begin
                failures++; $display("FAIL rnd_ctrl: iter %0d got %b/%b expected %b/%b", n, mem_reg_wr_ctrl, mem_misalign, mis ? 4'b0000 : exe_reg_wr_ctrl, mis);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; exe_valid = 1'b0; exe_reg_wr_ctrl = '0; exe_rd = '0; exe_data = '0;
        exe_st_data = '0; exe_pc = '0; exe_csr_data = '0; exe_mem_ctrl = '0; wb_allowin = 1'b1;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = '0;
        test_reset();
        test_nonmem();
        test_load_byte(1'b0);
        test_load_byte(1'b1);
        test_store_half();
        test_back_to_back();
        test_reset_in_resp();
        test_misalign();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
